// File: rtl/pci_pkg.sv
// Shared PCI target definitions: config command codes and target FSM states.
package pci_pkg;
  localparam logic [3:0] PCI_CMD_CFG_READ  = 4'b1010;
  localparam logic [3:0] PCI_CMD_CFG_WRITE = 4'b1011;

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    DEVSEL,
    RD_DATA,
    WR_DATA,
    TAR
  } pci_tgt_state_t;
endpackage

// File: rtl/pci_par_gen.sv
// Even parity across AD and C/BE#; used for both PAR drive and PAR check.
module pci_par_gen (
  input  logic [31:0] ad,
  input  logic [3:0]  cbe_n,
  output logic        par
);
  assign par = ^{ad, cbe_n};
endmodule

// File: rtl/pci_cfg_target.sv
// Type 0 configuration target: claims cfg cycles, one data phase
// per transaction, drives read data/PAR and checks address/write PAR.
module pci_cfg_target
  import pci_pkg::*;
#(
  parameter logic [2:0] FUNC_NUM     = 3'd0,
  parameter logic       CHECK_PARITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pci_frame_n,
  input  logic        pci_irdy_n,
  input  logic        pci_idsel,
  input  logic [31:0] pci_ad_in,
  input  logic [3:0]  pci_cbe_n,
  input  logic        pci_par_in,
  output logic [31:0] pci_ad_out,
  output logic        pci_ad_oe,
  output logic        pci_par_out,
  output logic        pci_par_oe,
  output logic        pci_trdy_n,
  output logic        pci_devsel_n,
  output logic        pci_stop_n,
  output logic        pci_ctl_oe,
  output logic        cfg_enable,
  output logic        cfg_iswrite,
  output logic [5:0]  cfg_offset,
  output logic [31:0] cfg_write_val,
  output logic [3:0]  cfg_byte_en,
  input  logic [31:0] cfg_read_val,
  output logic        parity_error
);

  pci_tgt_state_t state_q, state_d;

  logic        frame_q;
  logic        irdy_q;
  logic        wr_q;
  logic        rd_first;
  logic        chk_pend;
  logic        chk_par;
  logic [31:0] ad_q;
  logic        addr_phase;
  logic        claim;
  logic        xfer;
  logic        bus_idle;
  logic        rd_strobe;
  logic        wr_strobe;
  logic        gen_par;
  logic        in_par;

  assign addr_phase = !pci_frame_n && frame_q && irdy_q;
  assign claim = addr_phase && pci_idsel
    && (pci_ad_in[1:0] == 2'b00)
    && (pci_ad_in[10:8] == FUNC_NUM)
    && ((pci_cbe_n == PCI_CMD_CFG_READ)
     || (pci_cbe_n == PCI_CMD_CFG_WRITE));
  assign xfer      = !pci_irdy_n;
  assign bus_idle  = pci_frame_n && pci_irdy_n;
  assign rd_strobe = (state_q == IDLE) && claim
    && (pci_cbe_n == PCI_CMD_CFG_READ);
  assign wr_strobe = (state_q == WR_DATA) && xfer;

  // read data arrives the cycle after the strobe: pass it through
  // on the first data cycle, then hold the captured copy
  assign pci_ad_out = rd_first ? cfg_read_val : ad_q;

  pci_par_gen u_gen (
    .ad    (pci_ad_out),
    .cbe_n (pci_cbe_n),
    .par   (gen_par)
  );

  pci_par_gen u_chk (
    .ad    (pci_ad_in),
    .cbe_n (pci_cbe_n),
    .par   (in_par)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (claim)           state_d = DEVSEL;
        else if (addr_phase) state_d = BUSY;
      end
      BUSY:    if (bus_idle) state_d = IDLE;
      DEVSEL:  state_d = wr_q ? WR_DATA : RD_DATA;
      RD_DATA: if (xfer || bus_idle) state_d = TAR;
      WR_DATA: if (xfer || bus_idle) state_d = TAR;
      TAR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      frame_q       <= 1'b1;
      irdy_q        <= 1'b1;
      wr_q          <= 1'b0;
      rd_first      <= 1'b0;
      ad_q          <= '0;
      pci_ad_oe     <= 1'b0;
      pci_par_out   <= 1'b0;
      pci_par_oe    <= 1'b0;
      pci_trdy_n    <= 1'b1;
      pci_devsel_n  <= 1'b1;
      pci_stop_n    <= 1'b1;
      pci_ctl_oe    <= 1'b0;
      cfg_enable    <= 1'b0;
      cfg_iswrite   <= 1'b0;
      cfg_offset    <= '0;
      cfg_write_val <= '0;
      cfg_byte_en   <= '0;
      chk_pend      <= 1'b0;
      chk_par       <= 1'b0;
      parity_error  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= pci_frame_n;
      irdy_q       <= pci_irdy_n;
      pci_devsel_n <= !(state_d inside {DEVSEL, RD_DATA, WR_DATA});
      pci_trdy_n   <= !(state_d inside {RD_DATA, WR_DATA});
      pci_stop_n   <= !(state_d inside {RD_DATA, WR_DATA});
      pci_ctl_oe   <= state_d inside {DEVSEL, RD_DATA, WR_DATA, TAR};
      pci_ad_oe    <= (state_d == RD_DATA);
      pci_par_oe   <= pci_ad_oe;
      rd_first     <= (state_q == DEVSEL) && (state_d == RD_DATA);
      cfg_enable   <= rd_strobe || wr_strobe;
      if (rd_first)  ad_q <= cfg_read_val;
      if (pci_ad_oe) pci_par_out <= gen_par;
      if ((state_q == IDLE) && claim) begin
        cfg_offset <= pci_ad_in[7:2];
        wr_q       <= pci_cbe_n[0];
      end
      if (rd_strobe) cfg_iswrite <= 1'b0;
      if (wr_strobe) begin
        cfg_iswrite   <= 1'b1;
        cfg_write_val <= pci_ad_in;
        cfg_byte_en   <= ~pci_cbe_n;
      end
      // PAR for a phase arrives one clock after that phase
      chk_pend <= CHECK_PARITY
        && (((state_q == IDLE) && addr_phase) || wr_strobe);
      chk_par      <= in_par;
      parity_error <= chk_pend && (pci_par_in != chk_par);
    end
  end

endmodule

// File: tb/tb_pci_cfg_target.sv
// Randomized transaction bench for pci_cfg_target with a cycle-timeline
// model of the bus protocol and a register-file responder.
module tb_pci_cfg_target;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pci_frame_n, pci_irdy_n, pci_idsel, pci_par_in;
  logic [31:0] pci_ad_in;
  logic [3:0]  pci_cbe_n;
  logic [31:0] pci_ad_out;
  logic        pci_ad_oe, pci_par_out, pci_par_oe;
  logic        pci_trdy_n, pci_devsel_n, pci_stop_n, pci_ctl_oe;
  logic        cfg_enable, cfg_iswrite, parity_error;
  logic [5:0]  cfg_offset;
  logic [31:0] cfg_write_val;
  logic [3:0]  cfg_byte_en;
  logic [31:0] cfg_read_val = '0;

  always #5 clk = ~clk;

  pci_cfg_target dut (
    .clk           (clk),
    .rst           (rst),
    .pci_frame_n   (pci_frame_n),
    .pci_irdy_n    (pci_irdy_n),
    .pci_idsel     (pci_idsel),
    .pci_ad_in     (pci_ad_in),
    .pci_cbe_n     (pci_cbe_n),
    .pci_par_in    (pci_par_in),
    .pci_ad_out    (pci_ad_out),
    .pci_ad_oe     (pci_ad_oe),
    .pci_par_out   (pci_par_out),
    .pci_par_oe    (pci_par_oe),
    .pci_trdy_n    (pci_trdy_n),
    .pci_devsel_n  (pci_devsel_n),
    .pci_stop_n    (pci_stop_n),
    .pci_ctl_oe    (pci_ctl_oe),
    .cfg_enable    (cfg_enable),
    .cfg_iswrite   (cfg_iswrite),
    .cfg_offset    (cfg_offset),
    .cfg_write_val (cfg_write_val),
    .cfg_byte_en   (cfg_byte_en),
    .cfg_read_val  (cfg_read_val),
    .parity_error  (parity_error)
  );

  logic [31:0] mem [64];
  logic [31:0] ref_regs [64];
  int nerr = 0;
  int nchk = 0;

  logic        e_devsel_n, e_trdy_n, e_stop_n, e_ctl_oe;
  logic        e_ad_oe, e_par_oe, e_par, e_en, e_isw, e_perr;
  logic [31:0] e_ad, e_wval;
  logic [5:0]  e_off;
  logic [3:0]  e_be;
  bit          chk_on = 0;

  logic [31:0] cap_ad, cap_wval;
  logic        cap_par;
  logic [5:0]  cap_off;
  logic [3:0]  cap_be;
  int          en_cnt = 0;
  int          perr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic par36(input logic [31:0] a, input logic [3:0] c);
    return ^{a, c};
  endfunction

  // pci_cfg register file: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (cfg_enable) begin
      if (cfg_iswrite) begin
        for (int b = 0; b < 4; b++)
          if (cfg_byte_en[b])
            mem[cfg_offset][8*b +: 8] = cfg_write_val[8*b +: 8];
      end else begin
        cfg_read_val <= mem[cfg_offset];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("devsel_n", pci_devsel_n, e_devsel_n);
      chk("trdy_n", pci_trdy_n, e_trdy_n);
      chk("stop_n", pci_stop_n, e_stop_n);
      chk("ctl_oe", pci_ctl_oe, e_ctl_oe);
      chk("ad_oe", pci_ad_oe, e_ad_oe);
      chk("par_oe", pci_par_oe, e_par_oe);
      chk("cfg_enable", cfg_enable, e_en);
      chk("parity_error", parity_error, e_perr);
      if (e_ad_oe) chk("ad_out", pci_ad_out, e_ad);
      if (e_par_oe) chk("par_out", pci_par_out, e_par);
      if (e_en) begin
        chk("iswrite", cfg_iswrite, e_isw);
        chk("offset", cfg_offset, e_off);
        if (e_isw) begin
          chk("write_val", cfg_write_val, e_wval);
          chk("byte_en", cfg_byte_en, e_be);
        end
      end
    end
    if (pci_ad_oe) cap_ad <= pci_ad_out;
    if (pci_par_oe) cap_par <= pci_par_out;
    if (cfg_enable) begin
      cap_off  <= cfg_offset;
      cap_wval <= cfg_write_val;
      cap_be   <= cfg_byte_en;
      en_cnt   <= en_cnt + 1;
    end
    if (parity_error) perr_cnt <= perr_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_devsel_n = 1; e_trdy_n = 1; e_stop_n = 1; e_ctl_oe = 0;
    e_ad_oe = 0; e_par_oe = 0; e_par = 0; e_en = 0; e_isw = 0;
    e_perr = 0; e_ad = '0; e_wval = '0; e_off = '0; e_be = '0;
  endtask

  task automatic drive_idle();
    pci_frame_n = 1; pci_irdy_n = 1; pci_idsel = 0;
    pci_ad_in = $urandom; pci_cbe_n = 4'($urandom);
    pci_par_in = 1'($urandom);
  endtask

  // One bus transaction; timeline is relative to address phase k=0.
  // Claimed: DEVSEL at 1, data cycles 2..d, TAR at d+1, idle at d+2.
  task automatic run_txn(
    input logic [3:0] cmd, input logic idsel, input logic [2:0] fn,
    input logic [1:0] lo, input logic [5:0] off, input logic [31:0] wdata,
    input logic [3:0] be_n, input int w, input bit burst, input bit abort,
    input bit bad_ap, input bit bad_dp, input int rst_at);
    logic claim, rd, ap, irdy;
    logic [31:0] addr, rdata;
    int d, last;
    claim = idsel && (cmd == 4'b1010 || cmd == 4'b1011)
            && lo == 2'b00 && fn == 3'd0;
    rd    = !cmd[0];
    addr  = {21'($urandom), fn, off, lo};
    ap    = par36(addr, cmd) ^ bad_ap;
    d     = abort ? 2 : ((w + 1 > 2) ? w + 1 : 2);
    rdata = ref_regs[off];
    if (claim && !rd && !abort && rst_at < 0)
      for (int b = 0; b < 4; b++)
        if (!be_n[b]) ref_regs[off][8*b +: 8] = wdata[8*b +: 8];
    last = (rst_at >= 0) ? rst_at + 3 : (claim ? d + 3 : 6);
    for (int k = 0; k <= last; k++) begin
      step();
      drive_idle();
      set_idle();
      if (rst_at >= 0 && k >= rst_at) begin
        rst = (k <= rst_at + 1) ? 1'b0 : 1'b1;
        if (k == rst_at) begin
          #1;
          chk("rst_ad_oe", pci_ad_oe, 1'b0);
          chk("rst_par_oe", pci_par_oe, 1'b0);
          chk("rst_ctl_oe", pci_ctl_oe, 1'b0);
          chk("rst_devsel_n", pci_devsel_n, 1'b1);
          chk("rst_trdy_n", pci_trdy_n, 1'b1);
          chk("rst_stop_n", pci_stop_n, 1'b1);
          chk("rst_ad_out", pci_ad_out, 32'h0);
        end
        continue;
      end
      if (k == 0) begin
        pci_frame_n = 0; pci_ad_in = addr;
        pci_cbe_n = cmd; pci_idsel = idsel;
      end
      if (k == 1) pci_par_in = ap;
      if (!claim) begin
        if (k >= 1 && k <= 3) begin
          pci_frame_n = (k < 3) ? 1'b0 : 1'b1;
          pci_irdy_n  = 0;
        end
      end else if (!abort) begin
        if (k >= 1 && k <= d) begin
          irdy = (k < w + 1);
          pci_irdy_n  = irdy;
          pci_frame_n = (irdy || burst) ? 1'b0 : 1'b1;
          pci_cbe_n   = be_n;
          if (!rd) pci_ad_in = wdata;
        end
        if (k == d + 1) begin
          pci_cbe_n = be_n;
          if (burst) pci_irdy_n = 0;
          if (!rd) pci_par_in = par36(wdata, be_n) ^ bad_dp;
        end
      end else if (k >= 1 && k <= d) begin
        pci_cbe_n = be_n;
      end
      if (bad_ap && k == 2) e_perr = 1;
      if (claim) begin
        if (k == 1) begin
          e_devsel_n = 0; e_ctl_oe = 1;
          if (rd) begin e_en = 1; e_isw = 0; e_off = off; end
        end
        if (k >= 2 && k <= d) begin
          e_devsel_n = 0; e_trdy_n = 0; e_stop_n = 0; e_ctl_oe = 1;
          e_ad_oe = rd; e_ad = rdata;
        end
        if (rd && k >= 3 && k <= d + 1) begin
          e_par_oe = 1; e_par = par36(rdata, be_n);
        end
        if (k == d + 1) begin
          e_ctl_oe = 1;
          if (!rd && !abort) begin
            e_en = 1; e_isw = 1; e_off = off;
            e_wval = wdata; e_be = ~be_n;
          end
        end
        if (!rd && !abort && bad_dp && k == d + 2) e_perr = 1;
      end
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int e0, p0, r;
    logic [3:0] cmd;
    for (int i = 0; i < 64; i++) begin
      ref_regs[i] = $urandom;
      mem[i] = ref_regs[i];
    end
    ref_regs[0] = 32'h11E81234;
    mem[0] = 32'h11E81234;
    drive_idle();
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ad_oe", pci_ad_oe, 1'b0);
    chk("reset_ctl_oe", pci_ctl_oe, 1'b0);
    chk("reset_devsel_n", pci_devsel_n, 1'b1);
    chk("reset_trdy_n", pci_trdy_n, 1'b1);
    chk("reset_stop_n", pci_stop_n, 1'b1);
    chk("reset_cfg_enable", cfg_enable, 1'b0);
    chk("reset_iswrite", cfg_iswrite, 1'b0);
    chk("reset_offset", cfg_offset, 6'h0);
    chk("reset_write_val", cfg_write_val, 32'h0);
    chk("reset_byte_en", cfg_byte_en, 4'h0);
    chk("reset_ad_out", pci_ad_out, 32'h0);
    chk("reset_par", {pci_par_out, pci_par_oe, parity_error}, 3'b000);
    step();
    rst = 1;
    chk_on = 1;
    step();

    e0 = en_cnt;
    run_txn(4'b1010, 1, 3'd0, 2'b00, 6'h00, 32'h0, 4'b0000,
            1, 0, 0, 0, 0, -1);
    chk("pin_rd_ad", cap_ad, 32'h11E81234);
    chk("pin_rd_par", cap_par, 1'b1);
    chk("pin_rd_strobes", en_cnt - e0, 1);

    run_txn(4'b1011, 1, 3'd0, 2'b00, 6'h0F, 32'h0000000B, 4'b1110,
            0, 0, 0, 0, 0, -1);
    chk("pin_wr_off", cap_off, 6'h0F);
    chk("pin_wr_val", cap_wval, 32'h0000000B);
    chk("pin_wr_be", cap_be, 4'b0001);
    run_txn(4'b1010, 1, 3'd0, 2'b00, 6'h0F, 32'h0, 4'b0000,
            2, 0, 0, 0, 0, -1);
    chk("pin_rdback_byte0", cap_ad[7:0], 8'h0B);

    e0 = en_cnt;
    run_txn(4'b1010, 0, 3'd0, 2'b00, 6'h01, 32'h0, 4'b0000, 0, 0, 0, 0, 0, -1);
    run_txn(4'b1010, 1, 3'd1, 2'b00, 6'h01, 32'h0, 4'b0000, 0, 0, 0, 0, 0, -1);
    run_txn(4'b0110, 1, 3'd0, 2'b00, 6'h01, 32'h0, 4'b0000, 0, 0, 0, 0, 0, -1);
    chk("pin_noclaim_strobes", en_cnt - e0, 0);

    e0 = en_cnt;
    run_txn(4'b1010, 1, 3'd0, 2'b00, 6'h05, 32'h0, 4'b0000, 0, 1, 0, 0, 0, -1);
    chk("pin_burst_strobes", en_cnt - e0, 1);

    p0 = perr_cnt;
    e0 = en_cnt;
    run_txn(4'b1011, 1, 3'd0, 2'b00, 6'h07, 32'hA5A5_5A5A, 4'b0000,
            1, 0, 0, 1, 1, -1);
    chk("pin_perr_pulses", perr_cnt - p0, 2);
    chk("pin_perr_write_done", en_cnt - e0, 1);

    run_txn(4'b1010, 1, 3'd0, 2'b00, 6'h09, 32'h0, 4'b0000, 5, 0, 0, 0, 0, 3);
    run_txn(4'b1010, 1, 3'd0, 2'b00, 6'h09, 32'h0, 4'b0000, 1, 0, 0, 0, 0, -1);

    e0 = en_cnt;
    run_txn(4'b1011, 1, 3'd0, 2'b00, 6'h0A, 32'h1234_5678, 4'b0000,
            0, 0, 1, 0, 0, -1);
    chk("pin_abort_no_strobe", en_cnt - e0, 0);
    run_txn(4'b1010, 1, 3'd0, 2'b00, 6'h0A, 32'h0, 4'b0000, 0, 0, 1, 0, 0, -1);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 4) ? 4'b1010 : (r < 8) ? 4'b1011 : 4'($urandom);
      run_txn(cmd, $urandom_range(0, 7) != 0,
              ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0,
              ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0,
              6'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
